// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: operation request, direct HI/LO write and result signals of muldiv_seq.
// The master side issues operations; the slave side is the muldiv_seq unit.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [1:0]       OP;
  logic             SIGN;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             WE_HI;
  logic             WE_LO;
  logic [WIDTH-1:0] WD;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output START, OP, SIGN, A, B, WE_HI, WE_LO, WD,
    input  BUSY, DONE, HI, LO
  );

  modport slave (
    input  START, OP, SIGN, A, B, WE_HI, WE_LO, WD,
    output BUSY, DONE, HI, LO
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply / multiply-accumulate / divide unit with HI/LO registers.
// Optional macro MULDIV_FAST_MUL_EN: MUL/MAD use a single-cycle combinational multiplier.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic         CLK,
  input logic         RESET_N,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MAD = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   mag_a, mag_b, a_raw, hi_q, lo_q;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
  logic [2*WIDTH-1:0] acc, prod_mag, prod_sgn, hilo_res;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               res_neg, rem_neg, div_zero, done_q, busy;
  logic               accept, fast_path;

  assign accept = (state == IDLE) && bus.START && (bus.OP != OP_RSV);
  assign abs_a  = (bus.SIGN && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign abs_b  = (bus.SIGN && bus.B[WIDTH-1]) ? -bus.B : bus.B;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_path = !bus.OP[1];
`else
  assign fast_path = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast_path ? FINISH : RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Multiply: acc = {partial sum, remaining multiplier bits}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : (WIDTH+1)'(0));
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
  end

  // The most-negative / -1 case needs no special path: magnitudes give 2^(WIDTH-1) rem 0, sign positive.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_mag = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
    prod_mag = acc;
`endif
    prod_sgn = res_neg ? -prod_mag : prod_mag;
    quo      = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem      = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MAD:  hilo_res = {hi_q, lo_q} + prod_sgn;
      OP_DIV:  hilo_res = div_zero ? {a_raw, {WIDTH{1'b1}}} : {rem, quo};
      default: hilo_res = prod_sgn;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      a_raw    <= '0;
      op_q     <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            a_raw    <= bus.A;
            op_q     <= bus.OP;
            res_neg  <= bus.SIGN & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            rem_neg  <= bus.SIGN & bus.A[WIDTH-1];
            div_zero <= (bus.B == '0);
            acc      <= {{WIDTH{1'b0}}, (bus.OP == OP_DIV) ? abs_a : abs_b};
            cnt      <= '0;
          end else if (!bus.START) begin
            if (bus.WE_HI) hi_q <= bus.WD;
            if (bus.WE_LO) lo_q <= bus.WD;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_q == OP_DIV)
            acc <= {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                    acc[WIDTH-2:0], ~div_diff[WIDTH]};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        FINISH: begin
          {hi_q, lo_q} <= hilo_res;
          done_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY = busy;
  assign bus.DONE = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule
